io_bcd_converter: RTL and testbench

Memory-mapped IO-bus peripheral that converts a 16-bit binary value written by the CPU into five packed BCD digits, using a sequential shift-add-3 (double-dabble) engine. It sits between the CPU IO write bus and the seven-segment display register stage, which consumes `bcd_out` digit by digit. This replaces wide combinational divide/modulo logic. It also offers a one-deep pending buffer and a readable status word.

---
 rtl/io_pkg.sv | 17 +
 rtl/io_bcd_converter_if.sv | 24 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/io_bcd_converter.sv | 110 +++++++++++
 tb/tb_io_bcd_converter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared IO-bus address map, converter sizing and FSM state type
package io_pkg;

  localparam logic [7:0] ADDR_DISP0 = 8'h80;
  localparam logic [7:0] ADDR_DISP1 = 8'h84;
  localparam logic [7:0] ADDR_DISP2 = 8'h88;
  localparam logic [7:0] ADDR_CONV  = 8'h8C;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } conv_state_t;

endpackage

// File: rtl/io_bcd_converter_if.sv
// rtl/io_bcd_converter_if.sv - CPU IO bus bundle between the CPU and the BCD converter
interface io_bcd_converter_if;
  import io_pkg::*;

  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] io_read_data;

  modport master (
    output addr,
    output datain,
    output write_io_enable,
    input  io_read_data
  );

  modport slave (
    input  addr,
    input  datain,
    input  write_io_enable,
    output io_read_data
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_digit_adj
  import io_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/io_bcd_converter.sv
// rtl/io_bcd_converter.sv - sequential binary-to-BCD converter on the IO bus
module io_bcd_converter #(
  parameter int         BIN_W     = io_pkg::BIN_W,
  parameter int         DIGITS    = io_pkg::DIGITS,
  parameter logic [5:0] CONV_ADDR = io_pkg::ADDR_CONV[7:2]
) (
  input  logic                  io_clk,
  input  logic                  clrn,
  io_bcd_converter_if.slave     bus,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  busy
);
  import io_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  conv_state_t      state, state_nxt;
  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  sreg_shifted;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             pend_valid;
  logic [BIN_W-1:0] pend_data;
  logic             sel;
  logic             wr_hit;
  logic             last_shift;
  logic             unused_bits;

  assign sel        = (bus.addr[7:2] == CONV_ADDR);
  assign wr_hit     = bus.write_io_enable && sel;
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(BIN_W - 1));
  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.datain[31:BIN_W]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sreg[BIN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign sreg_shifted = {bcd_adj, sreg[BIN_W-1:0]} << 1;

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_hit) state_nxt = SHIFT;
      SHIFT:   if (last_shift && !pend_valid && !wr_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On the final shift a pending value takes priority; a coincident write then refills pending.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      sreg       <= '0;
      cnt        <= '0;
      bcd_out    <= '0;
      done       <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hit) begin
            sreg <= {{BCD_W{1'b0}}, bus.datain[BIN_W-1:0]};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          if (!last_shift) begin
            sreg <= sreg_shifted;
            cnt  <= cnt + 1'b1;
            if (wr_hit) begin
              pend_valid <= 1'b1;
              pend_data  <= bus.datain[BIN_W-1:0];
            end
          end else begin
            bcd_out <= sreg_shifted[SR_W-1:BIN_W];
            done    <= 1'b1;
            cnt     <= '0;
            if (pend_valid) begin
              sreg       <= {{BCD_W{1'b0}}, pend_data};
              pend_valid <= wr_hit;
              if (wr_hit) pend_data <= bus.datain[BIN_W-1:0];
            end else if (wr_hit) begin
              sreg <= {{BCD_W{1'b0}}, bus.datain[BIN_W-1:0]};
            end else begin
              sreg <= sreg_shifted;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);

  assign bus.io_read_data = sel ? 32'({pend_valid, busy, bcd_out}) : 32'h0;

endmodule

// File: tb/tb_io_bcd_converter.sv
// tb/tb_io_bcd_converter.sv - self-checking bench for io_bcd_converter against a behavioural model
module tb_io_bcd_converter;

  localparam logic [5:0] CONV_SEL = 6'h23;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pv;
    logic [5:0]  left;
    logic [15:0] val;
    logic [15:0] pend;
    logic [19:0] bcd;
  } model_t;

  logic        io_clk = 1'b0;
  logic        clrn   = 1'b0;
  logic [19:0] bcd_out;
  logic        done;
  logic        busy;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  model_t      m;

  io_bcd_converter_if bus ();

  io_bcd_converter dut (
    .io_clk  (io_clk),
    .clrn    (clrn),
    .bus     (bus),
    .bcd_out (bcd_out),
    .done    (done),
    .busy    (busy)
  );

  always #5 io_clk = ~io_clk;

  always @(posedge io_clk) cyc <= cyc + 1;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One IO clock of the converter as seen from outside: a job needs 16 edges after acceptance.
  function automatic model_t step(input model_t c, input logic hit, input logic [15:0] d);
    model_t n;
    n = c;
    n.done = 1'b0;
    if (!c.busy) begin
      if (hit) begin
        n.busy = 1'b1;
        n.val  = d;
        n.left = 6'd16;
      end
    end else if (c.left == 6'd1) begin
      n.bcd  = to_bcd(int'(c.val));
      n.done = 1'b1;
      if (c.pv) begin
        n.val  = c.pend;
        n.left = 6'd16;
        n.pv   = hit;
        if (hit) n.pend = d;
      end else if (hit) begin
        n.val  = d;
        n.left = 6'd16;
      end else begin
        n.busy = 1'b0;
        n.left = 6'd0;
      end
    end else begin
      n.left = c.left - 6'd1;
      if (hit) begin
        n.pv   = 1'b1;
        n.pend = d;
      end
    end
    return n;
  endfunction

  always @(posedge io_clk or negedge clrn) begin
    if (!clrn) m <= '0;
    else       m <= step(m, bus.write_io_enable && (bus.addr[7:2] == CONV_SEL), bus.datain[15:0]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge io_clk) begin
    check("busy", 32'(busy), 32'(m.busy));
    check("done", 32'(done), 32'(m.done));
    check("bcd_out", 32'(bcd_out), 32'(m.bcd));
    check("io_read_data", bus.io_read_data,
          (bus.addr[7:2] == CONV_SEL) ? 32'({m.pv, m.busy, m.bcd}) : 32'h0);
  end

  task automatic drive_write(input logic [7:0] a, input logic [15:0] v, output int t0);
    bus.addr            = {24'h0, a};
    bus.datain          = {16'($urandom), v};
    bus.write_io_enable = 1'b1;
    @(posedge io_clk);
    #2;
    t0 = cyc;
    bus.write_io_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge io_clk);
    #2;
  endtask

  task automatic wait_done(input int budget, output int at, output int nbusy);
    at    = -1;
    nbusy = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge io_clk);
      if (done) begin
        at = cyc;
        break;
      end
      if (busy) nbusy++;
    end
    if (at < 0) check("done_timeout", 32'h0, 32'h1);
    @(posedge io_clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tx, at, nb, ndone;
    logic [31:0] r, r2;
    logic [7:0]  a8;
    logic [15:0] v;

    bus.addr            = 32'h8C;
    bus.datain          = 32'h0;
    bus.write_io_enable = 1'b0;
    repeat (3) @(posedge io_clk);
    #2;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_status", bus.io_read_data, 32'h0);
    clrn = 1'b1;
    idle(2);

    drive_write(8'h8C, 16'd12345, t0);
    wait_done(40, at, nb);
    check("t1_latency", 32'(at - t0), 32'd16);
    check("t1_busy_cycles", 32'(nb), 32'd16);
    check("t1_bcd", 32'(bcd_out), 32'h12345);
    check("t1_status", bus.io_read_data, 32'h0001_2345);

    drive_write(8'h8C, 16'd0, t0);
    wait_done(40, at, nb);
    check("t2_zero", 32'(bcd_out), 32'h0);
    drive_write(8'h8C, 16'd65535, t0);
    wait_done(40, at, nb);
    check("t2_max", 32'(bcd_out), 32'h65535);

    drive_write(8'h8C, 16'd99, t0);
    idle(4);
    drive_write(8'h8C, 16'd250, tx);
    check("t3_e5", 32'(tx - t0), 32'd5);
    idle(3);
    drive_write(8'h8C, 16'd7, tx);
    check("t3_e9", 32'(tx - t0), 32'd9);
    check("t3_pend_busy", 32'(bus.io_read_data[21:20]), 32'h3);
    wait_done(40, at, nb);
    check("t3_first_at", 32'(at - t0), 32'd16);
    check("t3_first_bcd", 32'(bcd_out), 32'h00099);
    wait_done(40, at, nb);
    check("t3_second_at", 32'(at - t0), 32'd32);
    check("t3_second_busy", 32'(nb), 32'd15);
    check("t3_second_bcd", 32'(bcd_out), 32'h00007);

    drive_write(8'h8C, 16'd42, t0);
    idle(15);
    drive_write(8'h8C, 16'd1000, tx);
    check("t4_e16", 32'(tx - t0), 32'd16);
    wait_done(40, at, nb);
    check("t4_first_at", 32'(at - t0), 32'd16);
    check("t4_first_bcd", 32'(bcd_out), 32'h00042);
    wait_done(40, at, nb);
    check("t4_second_at", 32'(at - t0), 32'd32);
    check("t4_second_bcd", 32'(bcd_out), 32'h01000);

    drive_write(8'h8C, 16'd4321, t0);
    idle(7);
    @(posedge io_clk);
    #2;
    clrn = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    check("t5_bcd", 32'(bcd_out), 32'h0);
    check("t5_status", bus.io_read_data, 32'h0);
    idle(2);
    clrn  = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge io_clk);
      if (done) ndone++;
    end
    check("t5_no_done", 32'(ndone), 32'h0);
    idle(1);
    drive_write(8'h8C, 16'd5, t0);
    wait_done(40, at, nb);
    check("t5_fresh", 32'(bcd_out), 32'h00005);

    drive_write(8'h80, 16'd1234, t0);
    drive_write(8'h88, 16'd1234, t0);
    idle(3);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_bcd", 32'(bcd_out), 32'h00005);
    bus.addr = 32'h84;
    #1;
    check("t6_read84", bus.io_read_data, 32'h0);
    idle(1);

    for (int i = 0; i < 700; i++) begin
      r  = $urandom;
      r2 = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    a8 = 8'h8C;
        2:       a8 = 8'h80;
        3:       a8 = 8'h84;
        default: a8 = 8'h88;
      endcase
      case ($urandom_range(0, 7))
        0:       v = 16'd0;
        1:       v = 16'hFFFF;
        2:       v = 16'd9999;
        default: v = r2[15:0];
      endcase
      bus.addr            = {r[31:8], a8[7:2], r[1:0]};
      bus.datain          = {r2[31:16], v};
      bus.write_io_enable = ($urandom_range(0, 5) == 0);
      @(posedge io_clk);
      #2;
    end
    bus.write_io_enable = 1'b0;
    bus.addr            = 32'h8C;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
